// File: rtl/alu_mdu.sv
// Execution unit: single-cycle base ALU, branch/JALR resolution,
// pipelined RV32M multiply and iterative restoring divide.
module alu_mdu #(
    parameter int XLEN       = 32,
    parameter int ROB_ID_W   = 4,
    parameter int OP_W       = 7,
    parameter int HAS_M      = 1,
    parameter int MUL_STAGES = 2,
    parameter int DIV_STEPS  = 1
) (
    input  logic                clk,
    input  logic                rst_in,
    input  logic                rdy_in,
    input  logic                execute,
    input  logic                flush,
    input  logic [OP_W-1:0]     op_type,
    input  logic [XLEN-1:0]     val1,
    input  logic [XLEN-1:0]     val2,
    input  logic [ROB_ID_W-1:0] entry,
    input  logic [XLEN-1:0]     nowPC,
    output logic                in_ready,
    output logic                aluReady,
    output logic [ROB_ID_W-1:0] entry_out,
    output logic [XLEN-1:0]     val_out,
    output logic [XLEN-1:0]     alu2if_pc,
    output logic                alu2if_con
);

    localparam int SH_W    = $clog2(XLEN);
    localparam int DIV_CYC = XLEN / DIV_STEPS;
    localparam int CNT_W   = $clog2(DIV_CYC + MUL_STAGES) + 1;
    localparam bit M_EN    = (HAS_M != 0);

    localparam logic [2:0] OP_B_TYPE = 3'd1;
    localparam logic [2:0] OP_I_TYPE = 3'd2;
    localparam logic [2:0] OP_R_TYPE = 3'd3;
    localparam logic [2:0] OP_L_TYPE = 3'd4;
    localparam logic [2:0] OP_S_TYPE = 3'd5;
    localparam logic [2:0] OP_U_TYPE = 3'd6;
    localparam logic [2:0] OP_M_TYPE = 3'd7;

    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CNT_W-1:0] MUL_CNT0 =
        CNT_W'(MUL_STAGES > 1 ? MUL_STAGES - 2 : 0);
    localparam logic [CNT_W-1:0] DIV_CNT0 = CNT_W'(DIV_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV
    } state_e;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [2:0]            f3_q, f3_d;
    logic [ROB_ID_W-1:0]   tag_q, tag_d;
    logic signed [XLEN:0]  mul_a_q, mul_a_d;
    logic signed [XLEN:0]  mul_b_q, mul_b_d;
    logic [XLEN-1:0]       quo_q, quo_d;
    logic [XLEN-1:0]       rem_q, rem_d;
    logic [XLEN-1:0]       dvs_q, dvs_d;
    logic                  negq_q, negq_d;
    logic                  negr_q, negr_d;
    logic                  rdy_q, rdy_d;
    logic                  con_q, con_d;
    logic [XLEN-1:0]       val_q, val_d;
    logic [ROB_ID_W-1:0]   ent_q, ent_d;
    logic [XLEN-1:0]       pc_q, pc_d;

    logic [2:0]            cls, f3;
    logic                  v;
    logic [SH_W-1:0]       shamt;
    logic [XLEN-1:0]       sum, diff;
    logic                  lt_s, lt_u;
    logic [XLEN-1:0]       base_res;
    logic                  base_jalr;
    logic                  is_m;

    logic                  a_neg, b_neg, mul_fin;
    logic signed [2*XLEN+1:0] prod;
    logic [XLEN-1:0]       mul_res, div_res;
    logic [XLEN:0]         r_ext;
    logic [XLEN-1:0]       q_t, r_t;

    assign cls   = op_type[6:4];
    assign f3    = op_type[3:1];
    assign v     = op_type[0];
    assign shamt = val2[SH_W-1:0];
    assign sum   = val1 + val2;
    assign diff  = val1 - val2;
    assign lt_s  = $signed(val1) < $signed(val2);
    assign lt_u  = val1 < val2;
    assign is_m  = M_EN && (cls == OP_M_TYPE);

    always_comb begin
        base_res  = '0;
        base_jalr = 1'b0;
        case (cls)
            OP_B_TYPE: begin
                case (f3)
                    3'b000: base_res = XLEN'(val1 == val2);
                    3'b001: base_res = XLEN'(val1 != val2);
                    3'b011: begin
                        base_res  = nowPC;
                        base_jalr = 1'b1;
                    end
                    3'b100: base_res = XLEN'(lt_s);
                    3'b101: base_res = XLEN'(!lt_s);
                    3'b110: base_res = XLEN'(lt_u);
                    3'b111: base_res = v ? sum : XLEN'(!lt_u);
                    default: base_res = '0;
                endcase
            end
            OP_I_TYPE, OP_R_TYPE: begin
                case (f3)
                    3'b000: base_res = (cls == OP_R_TYPE && v) ? diff : sum;
                    3'b001: base_res = val1 << shamt;
                    3'b010: base_res = XLEN'(lt_s);
                    3'b011: base_res = XLEN'(lt_u);
                    3'b100: base_res = val1 ^ val2;
                    3'b101: base_res = v ? XLEN'($signed(val1) >>> shamt)
                                         : (val1 >> shamt);
                    3'b110: base_res = val1 | val2;
                    default: base_res = val1 & val2;
                endcase
            end
            OP_L_TYPE, OP_S_TYPE, OP_U_TYPE: base_res = sum;
            default: base_res = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        f3_d    = f3_q;
        tag_d   = tag_q;
        mul_a_d = mul_a_q;
        mul_b_d = mul_b_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        rdy_d   = 1'b0;
        con_d   = 1'b0;
        val_d   = val_q;
        ent_d   = ent_q;
        pc_d    = pc_q;
        a_neg   = 1'b0;
        b_neg   = 1'b0;
        mul_fin = 1'b0;

        // One batch of restoring-division steps on the magnitudes
        q_t   = quo_q;
        r_t   = rem_q;
        r_ext = '0;
        for (int i = 0; i < DIV_STEPS; i++) begin
            r_ext = {r_t, q_t[XLEN-1]};
            q_t   = {q_t[XLEN-2:0], 1'b0};
            if (r_ext >= {1'b0, dvs_q}) begin
                r_ext  = r_ext - {1'b0, dvs_q};
                q_t[0] = 1'b1;
            end
            r_t = r_ext[XLEN-1:0];
        end
        div_res = f3_q[1] ? (negr_q ? -r_t : r_t)
                          : (negq_q ? -q_t : q_t);

        case (state_q)
            S_IDLE: begin
                if (execute && is_m && !f3[2]) begin
                    f3_d    = f3;
                    tag_d   = entry;
                    mul_a_d = {(f3 == 3'b001 || f3 == 3'b010) & val1[XLEN-1], val1};
                    mul_b_d = {(f3 == 3'b001) & val2[XLEN-1], val2};
                    if (MUL_STAGES <= 1) begin
                        mul_fin = 1'b1;
                        rdy_d   = 1'b1;
                        ent_d   = entry;
                    end else begin
                        state_d = S_MUL;
                        cnt_d   = MUL_CNT0;
                    end
                end else if (execute && is_m) begin
                    a_neg = !f3[0] & val1[XLEN-1];
                    b_neg = !f3[0] & val2[XLEN-1];
                    f3_d  = f3;
                    tag_d = entry;
                    if (val2 == '0) begin
                        rdy_d = 1'b1;
                        ent_d = entry;
                        val_d = f3[1] ? val1 : '1;
                    end else if (!f3[0] && val1 == MIN_INT && val2 == '1) begin
                        rdy_d = 1'b1;
                        ent_d = entry;
                        val_d = f3[1] ? '0 : MIN_INT;
                    end else begin
                        quo_d   = a_neg ? -val1 : val1;
                        dvs_d   = b_neg ? -val2 : val2;
                        rem_d   = '0;
                        negq_d  = a_neg ^ b_neg;
                        negr_d  = a_neg;
                        cnt_d   = DIV_CNT0;
                        state_d = S_DIV;
                    end
                end else if (execute) begin
                    rdy_d = 1'b1;
                    ent_d = entry;
                    val_d = base_res;
                    con_d = base_jalr;
                    if (base_jalr) begin
                        pc_d = sum & ~XLEN'(1);
                    end
                end
            end
            S_MUL: begin
                if (cnt_q == '0) begin
                    mul_fin = 1'b1;
                    rdy_d   = 1'b1;
                    ent_d   = tag_q;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DIV: begin
                quo_d = q_t;
                rem_d = r_t;
                if (cnt_q == '0) begin
                    rdy_d   = 1'b1;
                    ent_d   = tag_q;
                    val_d   = div_res;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Single shared multiplier fed by the next-state operands
        prod    = mul_a_d * mul_b_d;
        mul_res = (f3_d == 3'b000) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        if (mul_fin) begin
            val_d = mul_res;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_in) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            f3_q    <= '0;
            tag_q   <= '0;
            mul_a_q <= '0;
            mul_b_q <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            rdy_q   <= 1'b0;
            con_q   <= 1'b0;
            val_q   <= '0;
            ent_q   <= '0;
            pc_q    <= '0;
        end else if (flush) begin
            state_q <= S_IDLE;
            rdy_q   <= 1'b0;
            con_q   <= 1'b0;
        end else if (rdy_in) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            f3_q    <= f3_d;
            tag_q   <= tag_d;
            mul_a_q <= mul_a_d;
            mul_b_q <= mul_b_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            rdy_q   <= rdy_d;
            con_q   <= con_d;
            val_q   <= val_d;
            ent_q   <= ent_d;
            pc_q    <= pc_d;
        end
    end

    assign in_ready   = (state_q == S_IDLE);
    assign aluReady   = rdy_q;
    assign entry_out  = ent_q;
    assign val_out    = val_q;
    assign alu2if_pc  = pc_q;
    assign alu2if_con = con_q;

endmodule

// File: tb/tb_alu_mdu.sv
// Scoreboard bench for alu_mdu: directed vectors queued at issue,
// checked by an independent monitor on every result strobe.
module tb_alu_mdu;

    logic        clk = 1'b0;
    logic        rst_in = 1'b0;
    logic        rdy_in = 1'b1;
    logic        execute = 1'b0;
    logic        flush = 1'b0;
    logic [6:0]  op_type = '0;
    logic [31:0] val1 = '0;
    logic [31:0] val2 = '0;
    logic [3:0]  entry = '0;
    logic [31:0] nowPC = '0;
    logic        in_ready;
    logic        aluReady;
    logic [3:0]  entry_out;
    logic [31:0] val_out;
    logic [31:0] alu2if_pc;
    logic        alu2if_con;

    alu_mdu dut (
        .clk(clk), .rst_in(rst_in), .rdy_in(rdy_in),
        .execute(execute), .flush(flush), .op_type(op_type),
        .val1(val1), .val2(val2), .entry(entry), .nowPC(nowPC),
        .in_ready(in_ready), .aluReady(aluReady),
        .entry_out(entry_out), .val_out(val_out),
        .alu2if_pc(alu2if_pc), .alu2if_con(alu2if_con)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] val;
        logic [3:0]  tag;
        logic        jalr;
        logic [31:0] pc;
        int          edge_n;
    } exp_t;

    exp_t  eq[$];
    string nq[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    int    cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
        end
    endtask

    function automatic logic [6:0] mk(input logic [2:0] c,
                                      input logic [2:0] f, input logic v);
        return {c, f, v};
    endfunction

    task automatic issue(input string nm, input logic [6:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] tag, input logic [31:0] pc,
                         input logic [31:0] ev, input logic ej,
                         input logic [31:0] epc, input int lat,
                         input bit push, input int st_at, input int st_len);
        int w;
        exp_t e;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        chk({nm, " ready"}, 32'(in_ready), 32'd1);
        op_type = op;
        val1 = a;
        val2 = b;
        entry = tag;
        nowPC = pc;
        execute = 1'b1;
        if (push) begin
            e = '{ev, tag, ej, epc, cyc + lat + st_len};
            eq.push_back(e);
            nq.push_back(nm);
        end
        @(posedge clk);
        #1 execute = 1'b0;
        if (st_len > 0) begin
            repeat (st_at) @(negedge clk);
            rdy_in = 1'b0;
            repeat (st_len) @(negedge clk);
            rdy_in = 1'b1;
        end
    endtask

    task automatic idle_chk(input string nm);
        chk({nm, " aluReady"}, 32'(aluReady), 32'd0);
        chk({nm, " in_ready"}, 32'(in_ready), 32'd1);
        chk({nm, " val_out"}, val_out, 32'd0);
        chk({nm, " entry_out"}, 32'(entry_out), 32'd0);
        chk({nm, " pc"}, alu2if_pc, 32'd0);
        chk({nm, " con"}, 32'(alu2if_con), 32'd0);
    endtask

    initial begin
        exp_t  e;
        string nm;
        logic  rdy_s, rst_s;
        forever begin
            @(posedge clk);
            rdy_s = rdy_in;
            rst_s = rst_in;
            #1;
            if (rst_s && rdy_s && aluReady) begin
                if (eq.size() == 0) begin
                    chk("unexpected aluReady", 32'(aluReady), 32'd0);
                end else begin
                    e  = eq.pop_front();
                    nm = nq.pop_front();
                    chk({nm, " val"}, val_out, e.val);
                    chk({nm, " tag"}, 32'(entry_out), 32'(e.tag));
                    chk({nm, " edge"}, 32'(cyc), 32'(e.edge_n));
                    chk({nm, " con"}, 32'(alu2if_con), 32'(e.jalr));
                    if (e.jalr) chk({nm, " pc"}, alu2if_pc, e.pc);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        repeat (3) @(negedge clk);
        idle_chk("reset");
        rst_in = 1'b1;

        issue("add", mk(3, 0, 0), 7, 5, 3, 0, 12, 0, 0, 1, 1, 0, 0);
        rdy_in = 1'b0;
        @(posedge clk);
        #2;
        chk("stall hold strobe", 32'(aluReady), 32'd1);
        chk("stall hold val", val_out, 32'd12);
        rdy_in = 1'b1;
        issue("sra", mk(3, 5, 1), 32'h8000_0000, 35, 4, 0, 32'hF000_0000, 0, 0, 1, 1, 0, 0);
        issue("slt", mk(2, 2, 0), 32'hFFFF_FFFF, 1, 5, 0, 1, 0, 0, 1, 1, 0, 0);
        issue("sltu", mk(3, 3, 0), 32'hFFFF_FFFF, 1, 6, 0, 0, 0, 0, 1, 1, 0, 0);
        issue("sub", mk(3, 0, 1), 5, 7, 7, 0, 32'hFFFF_FFFE, 0, 0, 1, 1, 0, 0);
        issue("sll", mk(3, 1, 0), 1, 33, 8, 0, 2, 0, 0, 1, 1, 0, 0);
        issue("srl", mk(3, 5, 0), 32'h8000_0000, 4, 9, 0, 32'h0800_0000, 0, 0, 1, 1, 0, 0);
        issue("xor", mk(3, 4, 0), 32'hF0F0, 32'hFF00, 10, 0, 32'h0FF0, 0, 0, 1, 1, 0, 0);
        issue("or", mk(2, 6, 0), 32'hF0, 32'h0F, 11, 0, 32'hFF, 0, 0, 1, 1, 0, 0);
        issue("and", mk(3, 7, 0), 32'hF0, 32'h3C, 12, 0, 32'h30, 0, 0, 1, 1, 0, 0);
        issue("beq", mk(1, 0, 0), 5, 5, 13, 0, 1, 0, 0, 1, 1, 0, 0);
        issue("bne", mk(1, 1, 0), 5, 5, 14, 0, 0, 0, 0, 1, 1, 0, 0);
        issue("blt", mk(1, 4, 0), 32'hFFFF_FFFE, 1, 15, 0, 1, 0, 0, 1, 1, 0, 0);
        issue("bltu", mk(1, 6, 0), 32'hFFFF_FFFE, 1, 1, 0, 0, 0, 0, 1, 1, 0, 0);
        issue("bgeu", mk(1, 7, 0), 32'hFFFF_FFFE, 1, 2, 0, 1, 0, 0, 1, 1, 0, 0);
        issue("jal", mk(1, 7, 1), 32'h100, 32'h20, 3, 0, 32'h120, 0, 0, 1, 1, 0, 0);
        issue("jalr", mk(1, 3, 0), 32'h1001, 4, 4, 32'h204, 32'h204, 1, 32'h1004, 1, 1, 0, 0);
        @(posedge clk);
        #1 chk("jalr con drop", 32'(alu2if_con), 32'd0);
        issue("load", mk(4, 2, 0), 32'h1000, 32'h10, 5, 0, 32'h1010, 0, 0, 1, 1, 0, 0);
        issue("lui", mk(6, 0, 0), 0, 32'h1234_5000, 6, 0, 32'h1234_5000, 0, 0, 1, 1, 0, 0);
        issue("unused", mk(0, 0, 0), 3, 4, 7, 0, 0, 0, 0, 1, 1, 0, 0);

        issue("mulhu", mk(7, 3, 0), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 8, 0, 32'hFFFF_FFFE, 0, 0, 2, 1, 0, 0);
        @(negedge clk);
        chk("mul busy", 32'(in_ready), 32'd0);
        op_type = mk(3, 0, 0);
        val1 = 1;
        val2 = 1;
        entry = 9;
        execute = 1'b1;
        @(posedge clk);
        #1 execute = 1'b0;
        issue("mul", mk(7, 0, 0), 6, 32'hFFFF_FFF9, 9, 0, 32'hFFFF_FFD6, 0, 0, 2, 1, 0, 0);
        issue("mulh", mk(7, 1, 0), 32'h8000_0000, 32'h8000_0000, 10, 0, 32'h4000_0000, 0, 0, 2, 1, 0, 0);
        issue("mulhsu", mk(7, 2, 0), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 11, 0, 32'hFFFF_FFFF, 0, 0, 2, 1, 0, 0);

        issue("div", mk(7, 4, 0), 32'hFFFF_FFF9, 2, 12, 0, 32'hFFFF_FFFD, 0, 0, 33, 1, 0, 0);
        issue("rem", mk(7, 6, 0), 32'hFFFF_FFF9, 2, 13, 0, 32'hFFFF_FFFF, 0, 0, 33, 1, 0, 0);
        issue("divu", mk(7, 5, 0), 100, 7, 14, 0, 14, 0, 0, 33, 1, 0, 0);
        issue("remu", mk(7, 7, 0), 100, 7, 15, 0, 2, 0, 0, 33, 1, 0, 0);
        issue("div0", mk(7, 4, 0), 5, 0, 1, 0, 32'hFFFF_FFFF, 0, 0, 1, 1, 0, 0);
        issue("rem0", mk(7, 6, 0), 9, 0, 2, 0, 9, 0, 0, 1, 1, 0, 0);
        issue("divu0", mk(7, 5, 0), 5, 0, 3, 0, 32'hFFFF_FFFF, 0, 0, 1, 1, 0, 0);
        issue("div ovf", mk(7, 4, 0), 32'h8000_0000, 32'hFFFF_FFFF, 4, 0, 32'h8000_0000, 0, 0, 1, 1, 0, 0);
        issue("rem ovf", mk(7, 6, 0), 32'h8000_0000, 32'hFFFF_FFFF, 5, 0, 0, 0, 0, 1, 1, 0, 0);
        issue("divu stall", mk(7, 5, 0), 100, 7, 6, 0, 14, 0, 0, 33, 1, 10, 5);

        issue("div flushed", mk(7, 4, 0), 100, 7, 7, 0, 0, 0, 0, 33, 0, 0, 0);
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        chk("flush in_ready", 32'(in_ready), 32'd1);
        chk("flush aluReady", 32'(aluReady), 32'd0);
        repeat (40) @(negedge clk);
        issue("add post flush", mk(3, 0, 0), 1, 2, 8, 0, 3, 0, 0, 1, 1, 0, 0);

        issue("div reset", mk(7, 4, 0), 100, 7, 9, 0, 0, 0, 0, 33, 0, 0, 0);
        repeat (3) @(negedge clk);
        rst_in = 1'b0;
        @(posedge clk);
        #2 idle_chk("mid reset");
        @(negedge clk);
        rst_in = 1'b1;
        issue("add post reset", mk(3, 0, 0), 10, 20, 10, 0, 30, 0, 0, 1, 1, 0, 0);

        w = 0;
        while (eq.size() > 0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        repeat (3) @(negedge clk);
        chk("pending results", 32'(eq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
